scaled_addsub_pipe: RTL and testbench

SCALED_ADDSUB_PIPE -- requirements
Module: scaled_addsub_pipe

---
 rtl/scaled_addsub_pipe.sv | 269 ++++++++++++++++++++++++++
 tb/tb_scaled_addsub_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/scaled_addsub_pipe.sv
// ---------------------------------------------------------------------------
// scaled_addsub_pipe
//
// Purpose:
//   Three-stage pipelined adder/subtractor for scaled signed numbers.
//   Each operand word is {scale, mantissa}, where the value is
//   mantissa * 2^scale. The operand with the smaller scale is shifted left
//   so both share the larger scale. The two aligned values are then added
//   or subtracted at full aligned width. Finally the result is range-checked
//   against a MANT_W-bit mantissa and packed back into {scale, mantissa}.
//
//   Stages:
//     S1 align      : sign-extend, shift the smaller-scale operand, take max scale
//     S2 add/sub    : SUM_W-bit two's-complement add/sub with signed overflow
//     S3 range/pack : invalid flag, packed result, error counter
//
//   Flow control:
//     The only back-pressure source is a held, unconsumed result
//     (stall = out_valid && !out_ready). A stall freezes every stage.
//     Empty slots (bubbles) are not collapsed.
//
// Configuration:
//   SADD_SATURATE_EN - when defined, the mantissa of an invalid result is
//                      clamped to the most positive or most negative
//                      mantissa, following the sign of the true sum.
//                      When undefined, the mantissa is truncated.
//
// Parameters:
//   MANT_W  - signed mantissa width
//   SCALE_W - unsigned scale-factor width
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   in_valid  in   operand pair presented
//   in_ready  out  pipeline accepts the pair this cycle
//   in1, in2  in   {scale, signed mantissa} operands
//   sub       in   1: in1 - in2, 0: in1 + in2 (travels with its operands)
//   out_valid out  result held on out / invalid
//   out_ready in   consumer takes the result
//   out       out  {result scale, result mantissa}
//   invalid   out  result not representable (qualified by out_valid)
//   err_cnt   out  saturating count of delivered invalid results
// ---------------------------------------------------------------------------
module scaled_addsub_pipe #(
    parameter int MANT_W  = 13,
    parameter int SCALE_W = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MANT_W+SCALE_W-1:0]   in1,
    input  logic [MANT_W+SCALE_W-1:0]   in2,
    input  logic                        sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MANT_W+SCALE_W-1:0]   out,
    output logic                        invalid,
    output logic [7:0]                  err_cnt
);

    localparam int W     = MANT_W + SCALE_W;
    // The widest shift is 2^SCALE_W - 1, so this width holds any aligned
    // operand without loss.
    localparam int SUM_W = MANT_W + (32'sd1 <<< SCALE_W) - 32'sd1;
    localparam int EXT_W = SUM_W - MANT_W;

    // True when every bit from the top of the sum down to the mantissa
    // sign bit agrees, i.e. the value fits in a MANT_W-bit signed mantissa.
    function automatic logic fits_mantissa(input logic [SUM_W-1:0] s);
        logic [EXT_W:0] top;
        top = s[SUM_W-1:MANT_W-1];
        return (&top) | (~|top);
    endfunction

    // Sign-extend a mantissa to the aligned width.
    function automatic logic [SUM_W-1:0] sext(input logic [MANT_W-1:0] m);
        return {{EXT_W{m[MANT_W-1]}}, m};
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic stall_s;
    logic adv_s;

    // Output registers, exposed through the output ports.
    logic             out_valid_r;
    logic [W-1:0]     out_r;
    logic             invalid_r;
    logic [7:0]       err_cnt_r;

    assign stall_s   = out_valid_r & ~out_ready;
    assign adv_s     = ~stall_s;
    assign in_ready  = adv_s;

    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign invalid   = invalid_r;
    assign err_cnt   = err_cnt_r;

    // ------------------------------------------------------------------
    // S1: alignment
    // ------------------------------------------------------------------
    logic [SCALE_W-1:0] sc1_s;
    logic [SCALE_W-1:0] sc2_s;
    logic [SCALE_W-1:0] diff_s;
    logic [SCALE_W-1:0] scale_nxt_s;
    logic [SUM_W-1:0]   e1_s;
    logic [SUM_W-1:0]   e2_s;
    logic [SUM_W-1:0]   a_nxt_s;
    logic [SUM_W-1:0]   b_nxt_s;

    assign sc1_s = in1[W-1:MANT_W];
    assign sc2_s = in2[W-1:MANT_W];
    assign e1_s  = sext(in1[MANT_W-1:0]);
    assign e2_s  = sext(in2[MANT_W-1:0]);

    // Shift the smaller-scale operand up to the larger scale; ties shift by zero.
    always_comb begin
        diff_s      = {SCALE_W{1'b0}};
        scale_nxt_s = {SCALE_W{1'b0}};
        a_nxt_s     = {SUM_W{1'b0}};
        b_nxt_s     = {SUM_W{1'b0}};
        if (sc1_s >= sc2_s) begin
            diff_s      = sc1_s - sc2_s;
            scale_nxt_s = sc1_s;
            a_nxt_s     = e1_s;
            b_nxt_s     = e2_s << diff_s;
        end else begin
            diff_s      = sc2_s - sc1_s;
            scale_nxt_s = sc2_s;
            a_nxt_s     = e1_s << diff_s;
            b_nxt_s     = e2_s;
        end
    end

    logic               s1_valid_r;
    logic [SUM_W-1:0]   s1_a_r;
    logic [SUM_W-1:0]   s1_b_r;
    logic [SCALE_W-1:0] s1_scale_r;
    logic               s1_sub_r;

    // S1 register: capture the aligned beat when the pipeline advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {SUM_W{1'b0}};
            s1_b_r     <= {SUM_W{1'b0}};
            s1_scale_r <= {SCALE_W{1'b0}};
            s1_sub_r   <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r     <= a_nxt_s;
                s1_b_r     <= b_nxt_s;
                s1_scale_r <= scale_nxt_s;
                s1_sub_r   <= sub;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: add / subtract with signed overflow
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] sum_s;
    logic             v_s;

    // Full-width add or subtract. Overflow occurs when the result sign
    // disagrees with the operands: like signs for add, unlike for subtract.
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        v_s   = 1'b0;
        if (s1_sub_r) begin
            sum_s = s1_a_r - s1_b_r;
            v_s   = (s1_a_r[SUM_W-1] != s1_b_r[SUM_W-1]) &&
                    (sum_s[SUM_W-1] != s1_a_r[SUM_W-1]);
        end else begin
            sum_s = s1_a_r + s1_b_r;
            v_s   = (s1_a_r[SUM_W-1] == s1_b_r[SUM_W-1]) &&
                    (sum_s[SUM_W-1] != s1_a_r[SUM_W-1]);
        end
    end

    logic               s2_valid_r;
    logic [SUM_W-1:0]   s2_sum_r;
    logic               s2_v_r;
    logic [SCALE_W-1:0] s2_scale_r;

    // S2 register: capture sum, overflow and scale of the S1 beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= {SUM_W{1'b0}};
            s2_v_r     <= 1'b0;
            s2_scale_r <= {SCALE_W{1'b0}};
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sum_r   <= sum_s;
                s2_v_r     <= v_s;
                s2_scale_r <= s1_scale_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: range check and pack
    // ------------------------------------------------------------------
    logic              inv_nxt_s;
    logic [MANT_W-1:0] mant_nxt_s;

`ifdef SADD_SATURATE_EN
    localparam logic [MANT_W-1:0] MANT_MAX = {1'b0, {(MANT_W-1){1'b1}}};
    localparam logic [MANT_W-1:0] MANT_MIN = {1'b1, {(MANT_W-1){1'b0}}};

    logic true_neg_s;

    // After adder overflow the wrapped sign bit is inverted from the true sign.
    assign true_neg_s = s2_v_r ? ~s2_sum_r[SUM_W-1] : s2_sum_r[SUM_W-1];

    // Range check; clamp an unrepresentable result toward the sign of the true sum.
    always_comb begin
        inv_nxt_s  = s2_v_r | ~fits_mantissa(s2_sum_r);
        mant_nxt_s = s2_sum_r[MANT_W-1:0];
        if (inv_nxt_s) begin
            if (true_neg_s) begin
                mant_nxt_s = MANT_MIN;
            end else begin
                mant_nxt_s = MANT_MAX;
            end
        end else begin
            mant_nxt_s = s2_sum_r[MANT_W-1:0];
        end
    end
`else
    // Range check; an unrepresentable result keeps its low mantissa bits.
    always_comb begin
        inv_nxt_s  = s2_v_r | ~fits_mantissa(s2_sum_r);
        mant_nxt_s = s2_sum_r[MANT_W-1:0];
    end
`endif

    // S3 / output register: results are held stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_r       <= {W{1'b0}};
            invalid_r   <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_r     <= {s2_scale_r, mant_nxt_s};
                invalid_r <= inv_nxt_s;
            end
        end
    end

    // Error counter: count each delivered invalid result, stopping at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (out_valid_r && out_ready && invalid_r && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

endmodule

// File: tb/tb_scaled_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_scaled_addsub_pipe
//
// Directed testbench for scaled_addsub_pipe with default parameters
// (MANT_W=13, SCALE_W=3, 16-bit words). Every expected result comes from
// a hand-computed vector table. Results are matched in order through a
// queue of the vector indices that were accepted.
// ---------------------------------------------------------------------------
module tb_scaled_addsub_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        invalid;
    logic [7:0]  err_cnt;

    scaled_addsub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .invalid   (invalid),
        .err_cnt   (err_cnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int checks_n;
    int fails_n;
    int pops_n;
    int q[$];
    logic acc;
    logic prev_stall;
    logic [16:0] held;

    // Vector table: operands, op, expected packed result, expected invalid.
    logic [15:0] vin1     [8];
    logic [15:0] vin2     [8];
    logic        vsub     [8];
    logic [15:0] vexp_out [8];
    logic        vexp_inv [8];

    int sidx [5] = '{3, 2, 4, 7, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            fails_n++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, score the output
    // transfer about to happen, then advance past the next rising edge.
    task automatic cycle(input logic v, input int idx, input logic ordy, output logic accepted);
        int e;
        in_valid  = v;
        in1       = vin1[idx];
        in2       = vin2[idx];
        sub       = vsub[idx];
        out_ready = ordy;
        #1;
        if (prev_stall) check("stall_out_hold", 32'({invalid, out}), 32'(held));
        if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("out", 32'(out), 32'(vexp_out[e]));
                check("invalid", 32'(invalid), 32'(vexp_inv[e]));
                pops_n++;
            end
        end
        prev_stall = out_valid && !out_ready;
        held       = {invalid, out};
        accepted   = in_valid && in_ready;
        if (accepted) q.push_back(idx);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int idx);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 20 && !a; t++) cycle(1'b1, idx, 1'b1, a);
        if (!a) check("send_timeout", 32'(a), 32'd1);
    endtask

    task automatic drain(input int budget);
        logic a;
        for (int t = 0; t < budget && q.size() > 0; t++) cycle(1'b0, 0, 1'b1, a);
        check("drain_pending", 32'(q.size()), 32'd0);
    endtask

    initial begin
        checks_n = 0; fails_n = 0; pops_n = 0;
        prev_stall = 1'b0; held = 17'd0;
        clk = 1'b0; rst = 1'b1;
        in_valid = 1'b0; in1 = 16'h0000; in2 = 16'h0000; sub = 1'b0; out_ready = 1'b0;

        vin1[0] = 16'h4064; vin2[0] = 16'h0005; vsub[0] = 1'b0; vexp_out[0] = 16'h4078; vexp_inv[0] = 1'b0;
        vin1[1] = 16'h4064; vin2[1] = 16'h0005; vsub[1] = 1'b1; vexp_out[1] = 16'h4050; vexp_inv[1] = 1'b0;
        vin1[2] = 16'h0FFF; vin2[2] = 16'h0001; vsub[2] = 1'b0; vexp_inv[2] = 1'b1;
        vin1[3] = 16'h0003; vin2[3] = 16'h3FFF; vsub[3] = 1'b0; vexp_out[3] = 16'h2005; vexp_inv[3] = 1'b0;
        vin1[4] = 16'h7FF6; vin2[4] = 16'h6005; vsub[4] = 1'b1; vexp_out[4] = 16'h7FF1; vexp_inv[4] = 1'b0;
        vin1[5] = 16'h1000; vin2[5] = 16'h0001; vsub[5] = 1'b1; vexp_inv[5] = 1'b1;
        vin1[6] = 16'hFFFF; vin2[6] = 16'h1000; vsub[6] = 1'b0; vexp_inv[6] = 1'b1;
        vin1[7] = 16'hA064; vin2[7] = 16'h4003; vsub[7] = 1'b1; vexp_out[7] = 16'hA04C; vexp_inv[7] = 1'b0;
`ifdef SADD_SATURATE_EN
        vexp_out[2] = 16'h0FFF; vexp_out[5] = 16'h1000; vexp_out[6] = 16'hF000;
`else
        vexp_out[2] = 16'h1000; vexp_out[5] = 16'h0FFF; vexp_out[6] = 16'hFFFF;
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Latency of exactly three cycles
        cycle(1'b1, 0, 1'b1, acc);
        check("lat_c1", 32'(out_valid), 32'd0);
        cycle(1'b0, 0, 1'b1, acc);
        check("lat_c2", 32'(out_valid), 32'd0);
        cycle(1'b0, 0, 1'b1, acc);
        check("lat_c3", 32'(out_valid), 32'd1);
        drain(10);

        // Subtract, then the first overflowing beat
        send(1);
        drain(10);
        send(2);
        drain(10);
        check("err_cnt_first", 32'(err_cnt), 32'd1);

        // Back-to-back stream across scale orderings and signs
        for (int i = 3; i < 8; i++) send(i);
        drain(20);
        check("err_cnt_stream", 32'(err_cnt), 32'd3);

        // Five beats with the second result held for four cycles
        begin
            int sent;
            int p0;
            int stall_n;
            logic ordy;
            sent = 0; p0 = pops_n; stall_n = 0;
            for (int t = 0; t < 60 && (sent < 5 || q.size() > 0); t++) begin
                ordy = 1'b1;
                if (out_valid && (pops_n - p0) == 1 && stall_n < 4) begin
                    ordy = 1'b0;
                    stall_n++;
                end
                cycle(sent < 5, (sent < 5) ? sidx[sent] : 0, ordy, acc);
                if (acc) sent++;
            end
            check("stall_results", 32'(pops_n - p0), 32'd5);
            check("err_cnt_stall", 32'(err_cnt), 32'd4);
        end

        // Reset with three beats in flight
        send(0);
        send(2);
        send(5);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        prev_stall = 1'b0;
        out_ready = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 0, 1'b1, acc);
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        // Error counter saturation
        for (int i = 0; i < 254; i++) send(2);
        drain(10);
        check("err_cnt_254", 32'(err_cnt), 32'd254);
        for (int i = 0; i < 46; i++) send(2);
        drain(10);
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

endmodule
